// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for serial_digit_adder.
//   state_e   - FSM state encoding (IDLE, RUN, DONE)
//   steps     - number of digit steps, WIDTH/DIGIT
//   cnt_width - step counter width, $clog2(steps), never below 1 bit
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned steps(input int unsigned width,
                                        input int unsigned digit);
    return (digit == 0) ? 1 : width / digit;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned width,
                                            input int unsigned digit);
    int unsigned n;
    n = steps(width, digit);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple-carry row of full adders.
//   a_i, b_i  - digit operands
//   c_i       - carry into bit 0
//   s_o       - digit sum
//   c_o       - carry out of the top bit
//   c_msb_o   - carry into the top bit (for overflow on the last digit)
module digit_adder #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
    end
  end

  assign c_o     = c[DIGIT];
  assign c_msb_o = c[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// serial_digit_adder: digit-serial WIDTH-bit adder/subtractor, DIGIT bits per
// clock, LSB first, with a registered carry between digits.
//   clk, rst_n      - clock, asynchronous active-low reset
//   start           - request, accepted in IDLE or DONE
//   sub             - 0: a + b + cin, 1: a - b
//   a, b, cin       - operands, sampled with an accepted start
//   busy            - high while digits are processed
//   done            - one-cycle result-valid pulse
//   sum, cout, ovf  - registered result, carry out, two's-complement overflow
module serial_digit_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = steps(WIDTH, DIGIT);
  localparam int unsigned CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((DIGIT < 1) ? 1'b1 : ((DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0))) begin : g_bad_param
    $error("serial_digit_adder: DIGIT must divide WIDTH with 1 <= DIGIT <= WIDTH");
  end

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q, cout_q, ovf_q;
  logic              accept;
  logic [DIGIT-1:0]  dsum;
  logic              dcarry, dmsb;

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_i     (a_q[cnt_q*DIGIT +: DIGIT]),
    .b_i     (b_q[cnt_q*DIGIT +: DIGIT]),
    .c_i     (carry_q),
    .s_o     (dsum),
    .c_o     (dcarry),
    .c_msb_o (dmsb)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the registered state only, so no input reaches an output
  // combinationally.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath: operand capture on accept, one digit per RUN cycle.
  // Subtraction stores ~b and seeds the carry with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[cnt_q*DIGIT +: DIGIT] <= dsum;
      carry_q <= dcarry;
      cnt_q   <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        cout_q <= dcarry;
        ovf_q  <= dmsb ^ dcarry;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Testbench for serial_digit_adder: directed handshake/timing cases on an
// 8-bit/2-bit instance plus randomized operands across several WIDTH/DIGIT
// configurations, checked against an integer arithmetic reference model.
module tb_serial_digit_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic        cin;
  logic [31:0] a_in, b_in;

  logic [4:0]  busy_v, done_v, cout_v, ovf_v;
  logic [7:0]  sum_0, sum_1, sum_2, sum_3;
  logic [31:0] sum_4;

  int ncmp  = 0;
  int nfail = 0;

  localparam int NW [5] = '{8, 8, 8, 8, 32};
  localparam int NS [5] = '{4, 8, 2, 1, 4};

  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_d8x2 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_0), .cout(cout_v[0]), .ovf(ovf_v[0]));
  serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u_d8x1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_1), .cout(cout_v[1]), .ovf(ovf_v[1]));
  serial_digit_adder #(.WIDTH(8), .DIGIT(4)) u_d8x4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_2), .cout(cout_v[2]), .ovf(ovf_v[2]));
  serial_digit_adder #(.WIDTH(8), .DIGIT(8)) u_d8x8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin), .busy(busy_v[3]), .done(done_v[3]), .sum(sum_3), .cout(cout_v[3]), .ovf(ovf_v[3]));
  serial_digit_adder #(.WIDTH(32), .DIGIT(8)) u_d32x8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a_in), .b(b_in),
    .cin(cin), .busy(busy_v[4]), .done(done_v[4]), .sum(sum_4), .cout(cout_v[4]), .ovf(ovf_v[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] get_sum(input int idx);
    case (idx)
      0:       return {24'h0, sum_0};
      1:       return {24'h0, sum_1};
      2:       return {24'h0, sum_2};
      3:       return {24'h0, sum_3};
      default: return sum_4;
    endcase
  endfunction

  // Reference: unsigned result/carry and signed overflow from plain integers.
  task automatic model(input int w, input logic [31:0] ta, input logic [31:0] tb,
                       input logic ts, input logic tc,
                       output logic [31:0] es, output logic ec, output logic eo);
    longint m, ua, ub, sa, sb, r, sr;
    m  = longint'(1) << w;
    ua = longint'(ta) & (m - 1);
    ub = longint'(tb) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (ts) begin
      r  = ua - ub;
      ec = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + longint'(tc);
      ec = (r >= m);
      sr = sa + sb + longint'(tc);
    end
    es = 32'(r & (m - 1));
    eo = (sr > m / 2 - 1) || (sr < -(m / 2));
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request at a falling edge; returns one falling edge after the
  // rising edge that samples it.
  task automatic launch(input logic [31:0] ta, input logic [31:0] tb,
                        input logic ts, input logic tc);
    a_in  = ta;
    b_in  = tb;
    sub   = ts;
    cin   = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int idx, output int n, output int bc);
    n  = 0;
    bc = 0;
    while (done_v[idx] !== 1'b1 && n < 100) begin
      if (busy_v[idx] === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic ts, input logic tc);
    int n, bc;
    logic [31:0] es;
    logic ec, eo;
    launch({24'h0, ta}, {24'h0, tb}, ts, tc);
    wait_done(0, n, bc);
    model(8, {24'h0, ta}, {24'h0, tb}, ts, tc, es, ec, eo);
    check({tag, ".lat"},  n, 4);
    check({tag, ".busy"}, bc, 4);
    check({tag, ".sum"},  get_sum(0), es);
    check({tag, ".cout"}, cout_v[0], ec);
    check({tag, ".ovf"},  ovf_v[0], eo);
    @(negedge clk);
    check({tag, ".pulse"}, done_v[0], 1'b0);
  endtask

  initial begin
    int n, bc, pulses;
    logic [31:0] es;
    logic ec, eo;
    logic [31:0] ra, rb;
    logic rs, rc;
    int lat [5];
    logic [31:0] so [5];
    logic [4:0] co, ov;

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", busy_v[0], 1'b0);
    check("rst.done", done_v[0], 1'b0);
    check("rst.sum",  get_sum(0), 32'h0);
    check("rst.cout", cout_v[0], 1'b0);
    check("rst.ovf",  ovf_v[0], 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    do_op("ff+01",    8'hFF, 8'h01, 1'b0, 1'b0);
    check("ff+01.lit", {get_sum(0), cout_v[0], ovf_v[0]}, {32'h00, 1'b1, 1'b0});
    do_op("7f+01",    8'h7F, 8'h01, 1'b0, 1'b0);
    check("7f+01.lit", {get_sum(0), cout_v[0], ovf_v[0]}, {32'h80, 1'b0, 1'b1});
    do_op("12+34+c",  8'h12, 8'h34, 1'b0, 1'b1);
    check("12+34.lit", {get_sum(0), cout_v[0], ovf_v[0]}, {32'h47, 1'b0, 1'b0});
    do_op("80-01",    8'h80, 8'h01, 1'b1, 1'b1);
    check("80-01.lit", {get_sum(0), cout_v[0], ovf_v[0]}, {32'h7F, 1'b1, 1'b1});
    do_op("00-01",    8'h00, 8'h01, 1'b1, 1'b0);
    check("00-01.lit", {get_sum(0), cout_v[0], ovf_v[0]}, {32'hFF, 1'b0, 1'b0});

    // start during RUN is ignored
    launch(32'h55, 32'h22, 1'b0, 1'b0);
    @(negedge clk);
    a_in  = 32'hAA;
    b_in  = 32'hCC;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, n, bc);
    model(8, 32'h55, 32'h22, 1'b0, 1'b0, es, ec, eo);
    check("ign.lat",  n + 2, 4);
    check("ign.sum",  get_sum(0), es);
    check("ign.cout", cout_v[0], ec);
    check("ign.ovf",  ovf_v[0], eo);

    // Back-to-back: start accepted while done is high
    launch(32'h9C, 32'h3B, 1'b1, 1'b0);
    wait_done(0, n, bc);
    model(8, 32'h9C, 32'h3B, 1'b1, 1'b0, es, ec, eo);
    check("b2b.gap",  n + 1, 5);
    check("b2b.sum",  get_sum(0), es);
    check("b2b.cout", cout_v[0], ec);
    check("b2b.ovf",  ovf_v[0], eo);
    @(negedge clk);
    check("b2b.pulse", done_v[0], 1'b0);

    // Asynchronous reset in the third RUN cycle
    launch(32'hC3, 32'h5A, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("mid.busy_pre", busy_v[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid.busy", busy_v[0], 1'b0);
    check("mid.done", done_v[0], 1'b0);
    check("mid.sum",  get_sum(0), 32'h0);
    check("mid.cout", cout_v[0], 1'b0);
    check("mid.ovf",  ovf_v[0], 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) pulses++;
    end
    check("mid.nodone", pulses, 0);
    do_op("post_rst", 8'hE7, 8'h39, 1'b0, 1'b1);

    repeat (10) @(negedge clk);

    // Random sweep across all configurations in parallel
    for (int it = 0; it < 16; it++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      if (it == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h0000_0001; rs = 1'b0; rc = 1'b0; end
      if (it == 1) begin ra = 32'h8000_0080; rb = 32'h0000_0001; rs = 1'b1; rc = 1'b0; end
      for (int d = 0; d < 5; d++) begin
        lat[d] = -1;
        so[d]  = '0;
      end
      co = '0;
      ov = '0;
      launch(ra, rb, rs, rc);
      for (int k = 0; k <= 12; k++) begin
        for (int d = 0; d < 5; d++) begin
          if (done_v[d] === 1'b1 && lat[d] < 0) begin
            lat[d] = k;
            so[d]  = get_sum(d);
            co[d]  = cout_v[d];
            ov[d]  = ovf_v[d];
          end
        end
        @(negedge clk);
      end
      for (int d = 0; d < 5; d++) begin
        model(NW[d], ra, rb, rs, rc, es, ec, eo);
        check($sformatf("sw%0d.c%0d.lat", it, d),  lat[d], NS[d]);
        check($sformatf("sw%0d.c%0d.sum", it, d),  so[d], es);
        check($sformatf("sw%0d.c%0d.cout", it, d), co[d], ec);
        check($sformatf("sw%0d.c%0d.ovf", it, d),  ov[d], eo);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
